// File: rtl/hls_fp32_add_pkg.sv
// Shared definitions for the fp32 adder input-channel pipes.
// Holds the skid-buffer state encoding and the default widths.
package hls_fp32_add_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } chn_state_e;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/hls_fp32_add_sat_cnt.sv
// Generic saturating up-counter with synchronous clear.
// Clear takes priority over increment; the count sticks at all-ones.
module hls_fp32_add_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hls_fp32_add_chn_b_in_pipe.sv
// chn_b operand input stage: 2-entry skid buffer between the valid/ready
// producer and the core's rsc_z/rsc_vz/rsc_lz interface, plus a stall counter.
//
// state | meaning
// EMPTY | no operand held; rsc_vz low
// ONE   | head holds the operand on rsc_z
// TWO   | head on rsc_z, tail waiting behind it; upstream ready low
module hls_fp32_add_chn_b_in_pipe
  import hls_fp32_add_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             chn_b_pvld,
  output logic             chn_b_prdy,
  input  logic [DW-1:0]    chn_b_pd,
  output logic [DW-1:0]    chn_b_rsc_z,
  output logic             chn_b_rsc_vz,
  input  logic             chn_b_rsc_lz,
  output logic [1:0]       chn_b_occ,
  input  logic             stall_cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  chn_state_e    state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          push, pop;

  // Handshake outputs decode registered state only, so neither pvld/pd nor
  // rsc_lz has a combinational route to the opposite side.
  assign chn_b_rsc_vz = (state_q != EMPTY);
  assign chn_b_prdy   = (state_q != TWO) && !nvdla_core_rst;
  assign chn_b_rsc_z  = head_q;
  assign chn_b_occ    = state_q;

  assign push = chn_b_pvld && chn_b_prdy;
  assign pop  = chn_b_rsc_vz && chn_b_rsc_lz;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = chn_b_pd;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = chn_b_pd;
        end else if (push) begin
          state_d = TWO;
          tail_d  = chn_b_pd;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // prdy is low here, so only a pop can move the buffer
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  hls_fp32_add_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (nvdla_core_clk),
    .rst (nvdla_core_rst),
    .clr (stall_cnt_clr),
    .inc (chn_b_rsc_vz && !chn_b_rsc_lz),
    .cnt (stall_cnt)
  );

endmodule

// File: doc/hls_fp32_add_chn_b_in_pipe.md
Name: hls_fp32_add_chn_b_in_pipe

Overview:
- Upstream input stage for the fp32 adder's chn_b operand channel.
- Registers the NVDLA-side valid/ready stream (pvld/prdy/pd) into a 2-entry skid buffer.
- Presents the result to the core's chn_b rsci as a Catapult-style data/valid/load triple (rsc_z/rsc_vz/rsc_lz).
- Breaks every combinational path between the upstream producer and the core's wait-control logic, and provides a saturating backpressure-cycle counter for performance debug.

Parameters:
- DW, 32, operand payload width in bits.
- CNT_W, 16, width of the backpressure stall counter.

Ports:
- nvdla_core_clk  in  1  core clock; all state updates on the rising edge.
- nvdla_core_rst  in  1  synchronous reset, active-high.
- chn_b_pvld  in  1  upstream operand valid.
- chn_b_prdy  out  1  upstream ready; registered-only, no combinational input path.
- chn_b_pd  in  DW  upstream operand payload.
- chn_b_rsc_z  out  DW  operand to core rsci.
- chn_b_rsc_vz  out  1  operand valid to core; drives the core's chn_b_rsci_vd.
- chn_b_rsc_lz  in  1  core load strobe; a transfer occurs when rsc_vz & rsc_lz.
- chn_b_occ  out  2  entries held: 0, 1 or 2.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of cycles with rsc_vz=1 & rsc_lz=0.

Behaviour:
- Reset and clocking:
  - One clock, nvdla_core_clk.
  - nvdla_core_rst is synchronous and active-high.
- Reset values:
  - State EMPTY; head and tail registers 0.
  - rsc_vz=0, rsc_z=0, chn_occ=0, stall_cnt=0.
  - chn_b_prdy=0 while nvdla_core_rst=1; it rises in the first cycle after reset deasserts.
- Definitions:
  - push = chn_b_pvld & chn_b_prdy.
  - pop = chn_b_rsc_vz & chn_b_rsc_lz.
  - rsc_lz with rsc_vz=0 is ignored.
  - pvld with prdy=0 is ignored; the upstream producer must hold its data.
- State machine (states EMPTY / ONE / TWO; head register drives rsc_z):
  - EMPTY: push -> ONE, head<=pd. No push -> stay EMPTY.
  - ONE, push & pop -> stay ONE, head<=pd.
  - ONE, push only -> TWO, tail<=pd.
  - ONE, pop only -> EMPTY.
  - ONE, neither -> hold.
  - TWO: pop -> ONE, head<=tail. No pop -> hold. Push is impossible in TWO because prdy=0.
- Output decode (all from registered state only):
  - rsc_vz = (state != EMPTY).
  - chn_b_prdy = (state != TWO) & !nvdla_core_rst.
  - chn_occ = 0 / 1 / 2 for EMPTY / ONE / TWO.
- Latency and throughput:
  - An operand accepted at edge N appears on rsc_z/rsc_vz after edge N (visible in cycle N+1).
  - Sustained throughput is 1 operand/cycle with rsc_lz held high.
- Data integrity:
  - Strict FIFO order.
  - rsc_z is stable while rsc_vz=1 and no pop occurs.
  - No payload is duplicated or dropped across any EMPTY/ONE/TWO transition.
- stall_cnt:
  - Increments when rsc_vz & !rsc_lz.
  - Saturates at 2^CNT_W-1.
  - stall_cnt_clr has priority over increment; clear and stall in the same cycle yields 0.
- Reset mid-operation:
  - All buffered operands are discarded.
  - rsc_vz falls on the reset edge.
  - Upstream must re-present any operand not yet accepted.
- Combinational paths:
  - None from pvld/pd to the rsc_* outputs.
  - None from rsc_lz to prdy.

Decomposition:
- Shared package (hls_fp32_add_pkg) holds:
  - State encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Default DW/CNT_W constants.
- Sub-module: hls_fp32_add_sat_cnt (generic saturating counter with clear), instanced for stall_cnt.
- FSM and datapath stay in the top.

Test Plan:
- Reset release: hold rst 3 cycles with pvld=1 -> prdy=0 and vz=0 throughout; cycle after release prdy=1, occ=0.
- Single transfer: push pd=0x3F800000 at edge N, lz=0 -> vz=1 and z=0x3F800000 in cycle N+1, occ=1; lz=1 one cycle -> vz=0, occ=0.
- Fill / backpressure: lz=0, push 0x40000000 then 0x40400000 -> occ=2, prdy=0; third pvld is ignored; stall_cnt increments each cycle vz=1; then lz=1 for 2 cycles -> z=0x40000000 then 0x40400000, prdy returns 1 after the first pop.
- Streaming: lz=1 and pvld=1 for 100 cycles with incrementing pd -> every value is seen in order once, occ stays 1, prdy never drops.
- Counter saturation and clear: CNT_W=4, lz=0 with vz=1 for 20 cycles -> stall_cnt=15; assert stall_cnt_clr while still stalled -> 0 next cycle, then resumes 1, 2, ...
- Mid-operation reset: occ=2, then assert rst 1 cycle -> next cycle vz=0, occ=0, stall_cnt=0, prdy=0 during reset and 1 after.
